// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op codes, FSM encoding, default widths.
package alu_pkg;

  localparam int unsigned DEF_LEN_A = 4;
  localparam int unsigned DEF_LEN_B = 5;
  localparam int unsigned DEF_LEN_F = 5;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned PERF_W    = 16;

  localparam logic [OP_W-1:0] OP_NONE = 3'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 3'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 3'd2;
  localparam logic [OP_W-1:0] OP_AND  = 3'd3;
  localparam logic [OP_W-1:0] OP_OR   = 3'd4;
  localparam logic [OP_W-1:0] OP_LT   = 3'd5;
  localparam logic [OP_W-1:0] OP_SHL  = 3'd6;
  localparam logic [OP_W-1:0] OP_SHR  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Op code 0 is reserved as "no operation" and is rejected with an error response.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return op != OP_NONE;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant unit: a lone valid wins, a tie goes to the pointer.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic [1:0] o_gnt_c
);

  always_comb begin
    o_gnt_c = 2'b00;
    if (i_valid == 2'b11) begin
      o_gnt_c = i_ptr ? 2'b10 : 2'b01;
    end else begin
      o_gnt_c = i_valid;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters.
// Optional per-port accept counters are enabled with `define ALU_ARB_PERF_EN.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned LEN_A = DEF_LEN_A,
  parameter int unsigned LEN_B = DEF_LEN_B,
  parameter int unsigned LEN_F = DEF_LEN_F
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [LEN_A-1:0] req0_a,
  input  logic [LEN_B-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [LEN_A-1:0] req1_a,
  input  logic [LEN_B-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [LEN_F-1:0] rsp0_f,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [LEN_F-1:0] rsp1_f,
  output logic             rsp1_err,
  output logic [LEN_A-1:0] alu_a,
  output logic [LEN_B-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [LEN_F-1:0] alu_f
`ifdef ALU_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_cnt0,
  output logic [PERF_W-1:0] perf_cnt1
`endif
);

  state_t           r_state;
  state_t           w_next;
  logic             r_ptr;
  logic             r_owner;
  logic [LEN_A-1:0] r_a;
  logic [LEN_B-1:0] r_b;
  logic [OP_W-1:0]  r_op;
  logic [LEN_F-1:0] r_f;
  logic             r_err;

  logic [1:0]       w_gnt;
  logic             w_acc0;
  logic             w_acc1;
  logic             w_acc;
  logic             w_rsp_hs;
  logic [OP_W-1:0]  w_op_in;

  rr_arb2 u_rr_arb2 (
    .i_valid ({req1_valid, req0_valid}),
    .i_ptr   (r_ptr),
    .o_gnt_c (w_gnt)
  );

  assign req0_ready = (r_state == IDLE) && w_gnt[0];
  assign req1_ready = (r_state == IDLE) && w_gnt[1];
  assign w_acc0     = req0_valid && req0_ready;
  assign w_acc1     = req1_valid && req1_ready;
  assign w_acc      = w_acc0 || w_acc1;
  assign w_op_in    = w_acc1 ? req1_op : req0_op;

  // Response side is decoded from registered state, so reset clears it without a clock.
  assign rsp0_valid = (r_state == RESP) && !r_owner;
  assign rsp1_valid = (r_state == RESP) && r_owner;
  assign rsp0_f     = rsp0_valid ? r_f : '0;
  assign rsp1_f     = rsp1_valid ? r_f : '0;
  assign rsp0_err   = rsp0_valid && r_err;
  assign rsp1_err   = rsp1_valid && r_err;
  assign w_rsp_hs   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  // Operands stay parked on the ALU inputs; only the op code is gated to ISSUE.
  assign alu_a  = r_a;
  assign alu_b  = r_b;
  assign alu_op = (r_state == ISSUE) ? r_op : OP_NONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_next = is_legal_op(w_op_in) ? ISSUE : RESP;
      ISSUE:   w_next = RESP;
      RESP:    if (w_rsp_hs) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= 1'b0;
      r_owner <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= OP_NONE;
      r_f     <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_a     <= w_acc1 ? req1_a : req0_a;
        r_b     <= w_acc1 ? req1_b : req0_b;
        r_op    <= w_op_in;
        r_owner <= w_acc1;
        if (!is_legal_op(w_op_in)) begin
          r_f   <= '0;
          r_err <= 1'b1;
        end
      end
      if (r_state == ISSUE) begin
        r_f   <= alu_f;
        r_err <= 1'b0;
      end
      if (w_rsp_hs) begin
        r_ptr <= ~r_owner;
      end
    end
  end

`ifdef ALU_ARB_PERF_EN
  logic [PERF_W-1:0] r_cnt0;
  logic [PERF_W-1:0] r_cnt1;

  // Saturating per-port accept counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_acc0 && (r_cnt0 != '1)) r_cnt0 <= r_cnt0 + PERF_W'(1);
      if (w_acc1 && (r_cnt1 != '1)) r_cnt1 <= r_cnt1 + PERF_W'(1);
    end
  end

  assign perf_cnt0 = r_cnt0;
  assign perf_cnt1 = r_cnt1;
`else
  // No performance counters in this build.
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU and a response scoreboard.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0] req0_a, req1_a;
  logic [4:0] req0_b, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [4:0] rsp0_f, rsp1_f;
  logic       rsp0_err, rsp1_err;
  logic [3:0] alu_a;
  logic [4:0] alu_b;
  logic [2:0] alu_op;
  logic [4:0] alu_f;
`ifdef ALU_ARB_PERF_EN
  logic [15:0] perf_cnt0, perf_cnt1;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int n_rsp    = 0;

  typedef struct {
    bit         owner;
    logic [4:0] f;
    logic       err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_f(rsp0_f), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_f(rsp1_f), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_f(alu_f)
`ifdef ALU_ARB_PERF_EN
    , .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1)
`endif
  );

  function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] a, input logic [4:0] b);
    logic [4:0] ax;
    ax = 5'(a);
    case (op)
      3'd1:    return ax + b;
      3'd2:    return ax - b;
      3'd3:    return ax & b;
      3'd4:    return ax | b;
      3'd5:    return (ax < b) ? 5'd1 : 5'd0;
      3'd6:    return ax << b;
      3'd7:    return ax >> b;
      default: return 5'd0;
    endcase
  endfunction

  // External ALU stand-in.
  always_comb alu_f = alu_ref(alu_op, alu_a, alu_b);

  function automatic exp_t mk(input bit owner, input logic [2:0] op, input logic [3:0] a, input logic [4:0] b);
    exp_t e;
    e.owner = owner;
    e.err   = (op == 3'd0);
    e.f     = (op == 3'd0) ? 5'd0 : alu_ref(op, a, b);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pop_rsp(input bit p, input logic [4:0] f, input logic err);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_unexpected_rsp", 32'(p) + 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      n_rsp++;
      check("sb_owner", 32'(p), 32'(e.owner));
      check("sb_f", 32'(f), 32'(e.f));
      check("sb_err", 32'(err), 32'(e.err));
    end
  endtask

  // Scoreboard monitor: push on accept, pop on response handshake.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (req0_valid && req0_ready) sb.push_back(mk(1'b0, req0_op, req0_a, req0_b));
      if (req1_valid && req1_ready) sb.push_back(mk(1'b1, req1_op, req1_a, req1_b));
      if (rsp0_valid && rsp0_ready) pop_rsp(1'b0, rsp0_f, rsp0_err);
      if (rsp1_valid && rsp1_ready) pop_rsp(1'b1, rsp1_f, rsp1_err);
      if (rsp0_valid || rsp1_valid) check("rsp_exclusive", 32'(rsp0_valid & rsp1_valid), 32'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit p, input logic [3:0] a, input logic [4:0] b, input logic [2:0] op);
    bit got;
    got = 1'b0;
    if (p == 1'b0) begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end
    for (int i = 0; i < 20; i++) begin
      #2;
      got = (p == 1'b0) ? req0_ready : req1_ready;
      step();
      if (got) break;
    end
    check("send_accept", 32'(got), 32'd1);
    if (p == 1'b0) req0_valid = 1'b0;
    else           req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input bit p, input int exp_lat, input string tag);
    int lat;
    lat = 1;
    for (int i = 0; i < 20; i++) begin
      #2;
      if ((p == 1'b0) ? rsp0_valid : rsp1_valid) break;
      step();
      lat++;
    end
    check(tag, 32'(lat), 32'(exp_lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int order[$];
    int rsp_mark;
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    step(); step();

    // Reset state
    check("rst_req0_ready", 32'(req0_ready), 32'd0);
    check("rst_req1_ready", 32'(req1_ready), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_rsp_f", 32'({rsp0_f, rsp1_f}), 32'd0);
    check("rst_rsp_err", 32'({rsp0_err, rsp1_err}), 32'd0);
    check("rst_alu", 32'({alu_a, alu_b, alu_op}), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic add on port 0 with exact latency
    send(1'b0, 4'd3, 5'd4, OP_ADD);
    #1;
    check("t1_alu_op", 32'(alu_op), 32'd1);
    check("t1_alu_a", 32'(alu_a), 32'd3);
    check("t1_alu_b", 32'(alu_b), 32'd4);
    check("t1_rsp0_early", 32'(rsp0_valid), 32'd0);
    wait_rsp(1'b0, 2, "t1_latency");
    check("t1_f", 32'(rsp0_f), 32'd7);
    check("t1_err", 32'(rsp0_err), 32'd0);
    check("t1_rsp1_idle", 32'(rsp1_valid), 32'd0);
    check("t1_req1_idle", 32'(req1_ready), 32'd0);
    step();
    check("t1_back_idle", 32'(rsp0_valid), 32'd0);

    // Subtract wrap, then shift-left on port 1
    send(1'b0, 4'd2, 5'd5, OP_SUB);
    wait_rsp(1'b0, 2, "t2_sub_latency");
    check("t2_sub_f", 32'(rsp0_f), 32'd29);
    step();
    send(1'b1, 4'b1010, 5'd1, OP_SHL);
    wait_rsp(1'b1, 2, "t2_shl_latency");
    check("t2_shl_f", 32'(rsp1_f), 32'b10100);
    check("t2_shl_rsp0", 32'(rsp0_valid), 32'd0);
    step();

    // Illegal op returns error one cycle after accept, ALU never used
    send(1'b1, 4'd5, 5'd3, OP_NONE);
    check("t4_alu_op_n1", 32'(alu_op), 32'd0);
    wait_rsp(1'b1, 1, "t4_latency");
    check("t4_err", 32'(rsp1_err), 32'd1);
    check("t4_f", 32'(rsp1_f), 32'd0);
    check("t4_alu_op", 32'(alu_op), 32'd0);
    step();

    // Both valid from reset: round-robin order 0,1,0,1
    rst_n = 1'b0;
    req0_a = 4'd12; req0_b = 5'd10; req0_op = OP_AND; req0_valid = 1'b1;
    req1_a = 4'd5;  req1_b = 5'd6;  req1_op = OP_OR;  req1_valid = 1'b1;
    step();
    sb.delete();
    rst_n = 1'b1;
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      #2;
      if (req0_valid && req0_ready) order.push_back(0);
      if (req1_valid && req1_ready) order.push_back(1);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("t3_grants", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4 && i < order.size(); i++) check("t3_order", 32'(order[i]), 32'(i % 2));
    repeat (5) step();
    check("t3_drained", 32'(sb.size()), 32'd0);

    // Response backpressure on port 0 while port 1 waits
    rsp0_ready = 1'b0;
    req0_a = 4'd9; req0_b = 5'd9; req0_op = OP_ADD; req0_valid = 1'b1;
    #2;
    check("t5_acc0", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    req1_a = 4'd1; req1_b = 5'd1; req1_op = OP_ADD; req1_valid = 1'b1;
    #2;
    check("t5_issue_req1_ready", 32'(req1_ready), 32'd0);
    step();
    #2;
    check("t5_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("t5_rsp0_f", 32'(rsp0_f), 32'd18);
    for (int i = 0; i < 3; i++) begin
      step();
      #2;
      check("t5_hold_valid", 32'(rsp0_valid), 32'd1);
      check("t5_hold_f", 32'(rsp0_f), 32'd18);
      check("t5_hold_req1_ready", 32'(req1_ready), 32'd0);
    end
    step();
    rsp0_ready = 1'b1;
    #2;
    check("t5_hs_req1_ready", 32'(req1_ready), 32'd0);
    step();
    #2;
    check("t5_req1_accept", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    wait_rsp(1'b1, 2, "t5_rsp1_latency");
    check("t5_rsp1_f", 32'(rsp1_f), 32'd2);
    step();

    // Reset during RESP: asynchronous drop, then fresh arbitration from port 0
    rsp0_ready = 1'b0;
    send(1'b0, 4'd1, 5'd2, OP_ADD);
    step();
    #2;
    check("t6_in_resp", 32'(rsp0_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_async_drop", 32'(rsp0_valid), 32'd0);
    check("t6_async_f", 32'(rsp0_f), 32'd0);
    sb.delete();
    rsp0_ready = 1'b1;
    req0_a = 4'd3; req0_b = 5'd3; req0_op = OP_ADD; req0_valid = 1'b1;
    req1_a = 4'd2; req1_b = 5'd2; req1_op = OP_SUB; req1_valid = 1'b1;
    step();
    rst_n = 1'b1;
    rsp_mark = n_rsp;
    #2;
    check("t6_req0_first", 32'(req0_ready), 32'd1);
    check("t6_req1_wait", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    send(1'b1, 4'd2, 5'd2, OP_SUB);
    repeat (6) step();
    check("t6_rsp_count", 32'(n_rsp - rsp_mark), 32'd2);
    check("t6_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
